// File: rtl/df_edge_sched_pkg.sv
// df_edge_sched_pkg: shared constants and state encoding for the deblocking-filter edge scheduler
//   DF_N_EDGE / DF_N_SUB : edge slots per MB and rows (cycles) per edge
//   DF_LAST_EDGE         : index of the final edge slot
//   df_sched_state_e     : scheduler FSM states
package df_edge_sched_pkg;
    localparam int         DF_N_EDGE    = 48;
    localparam int         DF_N_SUB     = 4;
    localparam logic [5:0] DF_LAST_EDGE = 6'd47;

    typedef enum logic {
        DF_SCHED_IDLE = 1'b0,
        DF_SCHED_RUN  = 1'b1
    } df_sched_state_e;
endpackage

// File: rtl/df_edge_sched_cnt.sv
// df_edge_cnt: edge/row counter pair walking the DF read side through one MB
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : force both counters to 0 (dominates adv)
//   adv          : advance one row; row wraps into the next edge
//   edge_idx     : current edge slot
//   sub_idx      : row within the edge
//   last         : counters sit on the final row of the MB
module df_edge_cnt
    import df_edge_sched_pkg::*;
#(
    parameter logic [5:0] LAST_EDGE = DF_LAST_EDGE,
    parameter logic [1:0] LAST_SUB  = 2'(DF_N_SUB - 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       adv,
    output logic [5:0] edge_idx,
    output logic [1:0] sub_idx,
    output logic       last
);
    logic [5:0] edge_q, edge_d;
    logic [1:0] sub_q, sub_d;
    logic       sub_wrap;

    always_comb begin
        sub_wrap = sub_q == LAST_SUB;
        sub_d    = clr ? 2'd0 : adv ? (sub_wrap ? 2'd0 : sub_q + 2'd1) : sub_q;
        edge_d   = clr ? 6'd0 : (adv && sub_wrap) ? edge_q + 6'd1 : edge_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q <= 6'd0;
            sub_q  <= 2'd0;
        end else begin
            edge_q <= edge_d;
            sub_q  <= sub_d;
        end
    end

    assign edge_idx = edge_q;
    assign sub_idx  = sub_q;
    assign last     = sub_wrap && (edge_q == LAST_EDGE);
endmodule

// File: rtl/df_edge_sched.sv
// df_edge_sched: deblocking-filter edge scheduler and ping-pong RAM swap controller
//   clk, reset_n        : clock, asynchronous active-low reset
//   rec_mb_done         : reconstruction finished writing an MB (pulse)
//   df_ready            : downstream filter accepts the current row
//   end_of_MB_DEC       : RAM select swap pulse
//   DF_edge_counter_MR  : current edge slot
//   one_edge_counter_MR : row within edge
//   df_active           : counters valid this cycle
//   df_row_valid        : df_active delayed one cycle
//   df_mb_done          : pulse after the final row handshake of an MB
//   rec_stall           : reconstruction must hold off the next MB
//   ovf_err             : sticky, a completion arrived while a swap was already pending
module df_edge_sched
    import df_edge_sched_pkg::*;
#(
    parameter int N_EDGE = DF_N_EDGE,
    parameter int N_SUB  = DF_N_SUB
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rec_mb_done,
    input  logic       df_ready,
    output logic       end_of_MB_DEC,
    output logic [5:0] DF_edge_counter_MR,
    output logic [1:0] one_edge_counter_MR,
    output logic       df_active,
    output logic       df_row_valid,
    output logic       df_mb_done,
    output logic       rec_stall,
    output logic       ovf_err
);
    df_sched_state_e state_q, state_d;
    logic pend_q, pend_d, ovf_q, ovf_d, eom_q, eom_d;
    logic active_q, active_d, row_valid_q, mb_done_q, mb_done_d;
    logic run, last_hs, swap, cnt_clr, cnt_adv, cnt_last;

    df_edge_cnt #(
        .LAST_EDGE(6'(N_EDGE - 1)),
        .LAST_SUB (2'(N_SUB - 1))
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .adv     (cnt_adv),
        .edge_idx(DF_edge_counter_MR),
        .sub_idx (one_edge_counter_MR),
        .last    (cnt_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DF_SCHED_IDLE;
            pend_q      <= 1'b0;
            ovf_q       <= 1'b0;
            eom_q       <= 1'b0;
            active_q    <= 1'b0;
            row_valid_q <= 1'b0;
            mb_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            eom_q       <= eom_d;
            active_q    <= active_d;
            row_valid_q <= active_q;
            mb_done_q   <= mb_done_d;
        end
    end

    // A pending or coincident completion turns the final row straight into the next swap
    always_comb begin
        run     = state_q == DF_SCHED_RUN;
        last_hs = run && df_ready && cnt_last;
        swap    = (!run && rec_mb_done) || (last_hs && (pend_q || rec_mb_done));
        state_d = swap ? DF_SCHED_RUN : last_hs ? DF_SCHED_IDLE : state_q;
    end

    // The final-row swap consumes any pending completion, so pend never survives it
    always_comb begin
        cnt_clr   = !run || last_hs;
        cnt_adv   = run && df_ready;
        pend_d    = last_hs ? 1'b0 : (run && rec_mb_done) ? 1'b1 : pend_q;
        ovf_d     = ovf_q || (rec_mb_done && pend_q);
        eom_d     = swap;
        active_d  = state_d == DF_SCHED_RUN;
        mb_done_d = last_hs;
    end

    assign end_of_MB_DEC = eom_q;
    assign df_active     = active_q;
    assign df_row_valid  = row_valid_q;
    assign df_mb_done    = mb_done_q;
    assign rec_stall     = pend_q;
    assign ovf_err       = ovf_q;
endmodule

// File: tb/tb_df_edge_sched.sv
// tb_df_edge_sched: scenario tests plus randomized traffic against a row-count reference model
module tb_df_edge_sched;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rec_mb_done = 1'b0;
    logic       df_ready = 1'b0;
    logic       end_of_MB_DEC;
    logic [5:0] DF_edge_counter_MR;
    logic [1:0] one_edge_counter_MR;
    logic       df_active, df_row_valid, df_mb_done, rec_stall, ovf_err;
    int         checks = 0;
    int         errors = 0;

    // Reference model: an MB is 192 rows; edge = row/4, row-in-edge = row%4
    localparam int ROWS = 48 * 4;
    bit m_busy, m_pend, m_ovf, m_eom, m_done, m_rv;
    int m_row;

    always #5 clk = ~clk;

    df_edge_sched dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .rec_mb_done        (rec_mb_done),
        .df_ready           (df_ready),
        .end_of_MB_DEC      (end_of_MB_DEC),
        .DF_edge_counter_MR (DF_edge_counter_MR),
        .one_edge_counter_MR(one_edge_counter_MR),
        .df_active          (df_active),
        .df_row_valid       (df_row_valid),
        .df_mb_done         (df_mb_done),
        .rec_stall          (rec_stall),
        .ovf_err            (ovf_err)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_pend = 0; m_ovf = 0; m_eom = 0; m_done = 0; m_rv = 0; m_row = 0;
        end else begin
            m_rv   = m_busy;
            m_eom  = 0;
            m_done = 0;
            if (!m_busy) begin
                if (rec_mb_done) begin
                    m_busy = 1; m_row = 0; m_eom = 1;
                end
            end else if (df_ready && m_row == ROWS - 1) begin
                m_done = 1;
                m_row  = 0;
                if (rec_mb_done && m_pend) m_ovf = 1;
                if (m_pend || rec_mb_done) begin
                    m_eom = 1; m_pend = 0;
                end else begin
                    m_busy = 0;
                end
            end else begin
                if (rec_mb_done) begin
                    if (m_pend) m_ovf = 1;
                    m_pend = 1;
                end
                if (df_ready) m_row++;
            end
        end
    end

    function automatic logic [14:0] obs();
        return {end_of_MB_DEC, DF_edge_counter_MR, one_edge_counter_MR, df_active,
                df_row_valid, df_mb_done, rec_stall, ovf_err};
    endfunction

    function automatic logic [14:0] expv();
        return {m_eom, 6'(m_row / 4), 2'(m_row % 4), m_busy, m_rv, m_done, m_pend, m_ovf};
    endfunction

    task automatic drive(input logic rec, input logic rdy);
        rec_mb_done = rec;
        df_ready    = rdy;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (obs() !== 15'h0) begin
            errors++; $display("FAIL reset_state got %h want %h", obs(), 15'h0);
        end
        reset_n = 1'b1;
        repeat (3) begin
            drive(0, 1);
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL reset_idle got %h want %h", obs(), expv());
            end
        end
    endtask

    task automatic test_single_mb();
        int n = 0;
        int done_at = -1;
        drive(1, 1);
        checks++;
        if ({end_of_MB_DEC, df_active, DF_edge_counter_MR, one_edge_counter_MR} !== 10'b11_000000_00) begin
            errors++; $display("FAIL single_start got %b want 1100000000",
                {end_of_MB_DEC, df_active, DF_edge_counter_MR, one_edge_counter_MR});
        end
        while (done_at < 0 && n < 400) begin
            drive(0, 1); n++;
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL single_model n=%0d got %h want %h", n, obs(), expv());
            end
            if (df_mb_done === 1'b1) done_at = n;
        end
        checks++;
        if (done_at != 192) begin
            errors++; $display("FAIL single_latency got %0d want 192", done_at);
        end
        checks++;
        if ({df_active, end_of_MB_DEC, DF_edge_counter_MR, one_edge_counter_MR} !== 10'd0) begin
            errors++; $display("FAIL single_idle got %b want 0",
                {df_active, end_of_MB_DEC, DF_edge_counter_MR, one_edge_counter_MR});
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int done_at = -1;
        drive(1, 1);
        while (!(DF_edge_counter_MR == 6'd12 && one_edge_counter_MR == 2'd2) && n < 400) begin
            drive(0, 1); n++;
        end
        repeat (5) begin
            drive(0, 0); n++;
            checks++;
            if ({DF_edge_counter_MR, one_edge_counter_MR} !== {6'd12, 2'd2} || obs() !== expv()) begin
                errors++; $display("FAIL bp_hold got %0d/%0d want 12/2", DF_edge_counter_MR, one_edge_counter_MR);
            end
        end
        while (done_at < 0 && n < 600) begin
            drive(0, 1); n++;
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL bp_model n=%0d got %h want %h", n, obs(), expv());
            end
            if (df_mb_done === 1'b1) done_at = n;
        end
        checks++;
        if (done_at != 197) begin
            errors++; $display("FAIL bp_latency got %0d want 197", done_at);
        end
    endtask

    task automatic test_pending();
        int n = 0;
        int dones = 0;
        drive(1, 1);
        while (!(DF_edge_counter_MR == 6'd20 && one_edge_counter_MR == 2'd0) && n < 400) begin
            drive(0, 1); n++;
        end
        drive(1, 1);
        checks++;
        if (rec_stall !== 1'b1 || obs() !== expv()) begin
            errors++; $display("FAIL pend_stall_rise got %b want 1", rec_stall);
        end
        while (dones < 2 && n < 900) begin
            drive(0, 1); n++;
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL pend_model n=%0d got %h want %h", n, obs(), expv());
            end
            if (df_mb_done === 1'b1) begin
                dones++;
                checks++;
                if (dones == 1 && {end_of_MB_DEC, rec_stall, df_active, DF_edge_counter_MR, one_edge_counter_MR} !== 11'b101_000000_00) begin
                    errors++; $display("FAIL pend_swap got %b want 10100000000",
                        {end_of_MB_DEC, rec_stall, df_active, DF_edge_counter_MR, one_edge_counter_MR});
                end
                if (dones == 2 && {end_of_MB_DEC, df_active} !== 2'b00) begin
                    errors++; $display("FAIL pend_end got %b want 00", {end_of_MB_DEC, df_active});
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        int eoms = 0;
        bit stalled = 0;
        drive(1, 1);
        while (!(DF_edge_counter_MR == 6'd47 && one_edge_counter_MR == 2'd3) && n < 400) begin
            drive(0, 1); n++;
        end
        drive(1, 1);
        checks++;
        if ({df_mb_done, end_of_MB_DEC, rec_stall} !== 3'b110) begin
            errors++; $display("FAIL simul_swap got %b want 110", {df_mb_done, end_of_MB_DEC, rec_stall});
        end
        eoms = int'(end_of_MB_DEC);
        while (df_active === 1'b1 && n < 900) begin
            drive(0, 1); n++;
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL simul_model n=%0d got %h want %h", n, obs(), expv());
            end
            eoms += int'(end_of_MB_DEC);
            stalled |= rec_stall;
        end
        checks++;
        if (eoms != 1 || stalled) begin
            errors++; $display("FAIL simul_count got eoms=%0d stall=%0d want eoms=1 stall=0", eoms, stalled);
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        int dones = 0;
        logic rec;
        drive(1, 1);
        while (df_active === 1'b1 && n < 1200) begin
            rec = dones == 0 && one_edge_counter_MR == 2'd0 &&
                  (DF_edge_counter_MR == 6'd10 || DF_edge_counter_MR == 6'd15);
            drive(rec, 1); n++;
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL ovf_model n=%0d got %h want %h", n, obs(), expv());
            end
            dones += int'(df_mb_done);
        end
        checks++;
        if (ovf_err !== 1'b1 || dones != 2) begin
            errors++; $display("FAIL ovf_result got ovf=%b dones=%0d want ovf=1 dones=2", ovf_err, dones);
        end
        repeat (3) drive(0, 1);
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky got %b want 1", ovf_err);
        end
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        int done_at = -1;
        drive(1, 1);
        while (DF_edge_counter_MR != 6'd30 && n < 400) begin
            drive(0, 1); n++;
        end
        #2 reset_n = 1'b0;
        rec_mb_done = 1'b0;
        #1;
        checks++;
        if (obs() !== 15'h0) begin
            errors++; $display("FAIL rst_async got %h want %h", obs(), 15'h0);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 15'h0) begin
            errors++; $display("FAIL rst_hold got %h want %h", obs(), 15'h0);
        end
        reset_n = 1'b1;
        drive(0, 1);
        drive(1, 1);
        checks++;
        if ({end_of_MB_DEC, df_active, DF_edge_counter_MR, one_edge_counter_MR} !== 10'b11_000000_00) begin
            errors++; $display("FAIL rst_restart got %b want 1100000000",
                {end_of_MB_DEC, df_active, DF_edge_counter_MR, one_edge_counter_MR});
        end
        n = 0;
        while (done_at < 0 && n < 400) begin
            drive(0, 1); n++;
            if (df_mb_done === 1'b1) done_at = n;
        end
        checks++;
        if (done_at != 192) begin
            errors++; $display("FAIL rst_latency got %0d want 192", done_at);
        end
    endtask

    task automatic test_random();
        logic rec, rdy;
        for (int i = 0; i < 4000; i++) begin
            rec = $urandom_range(0, 299) == 0;
            rdy = $urandom_range(0, 3) != 0;
            if (m_busy && m_pend && m_row == ROWS - 1) rec = 1'b0;
            drive(rec, rdy);
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL random i=%0d got %h want %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_mb();
        test_backpressure();
        test_pending();
        test_simultaneous();
        test_overflow();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
